group_n_mac_ec: RTL and testbench



---
 rtl/group_n_mac_ec_if.sv | 38 +++
 rtl/group_n_mac_ec.sv | 121 ++++++++++++
 tb/tb_group_n_mac_ec.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/group_n_mac_ec_if.sv
// Bundle of the MAC group's data-path signals: operands, upstream partial sum and
// deferred error product going in, accumulated results and error flag coming out.
// master drives the operands (upstream stage / bench); slave is the MAC group.
interface group_n_mac_ec_if #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int PSW   = 24,
    parameter int EPW   = 2*DW + $clog2(LANES)
) ();
    logic                  valid_in;
    logic [LANES*DW-1:0]   weight_in;
    logic [LANES*DW-1:0]   activation_in;
    logic [PSW-1:0]        partial_sum_in;
    logic [EPW-1:0]        error_product_in;
    logic                  error_in;
    logic [LANES-1:0]      lane_err;

    logic                  valid_out;
    logic [LANES*DW-1:0]   next_activation;
    logic [PSW-1:0]        partial_sum_out;
    logic [EPW-1:0]        error_product_out;
    logic                  error_out;
    logic [15:0]           err_count;

    modport master (
        output valid_in, weight_in, activation_in, partial_sum_in,
               error_product_in, error_in, lane_err,
        input  valid_out, next_activation, partial_sum_out,
               error_product_out, error_out, err_count
    );

    modport slave (
        input  valid_in, weight_in, activation_in, partial_sum_in,
               error_product_in, error_in, lane_err,
        output valid_out, next_activation, partial_sum_out,
               error_product_out, error_out, err_count
    );
endinterface

// File: rtl/group_n_mac_ec.sv
// Purpose: LANES-wide multiply-accumulate group with timing-error compensation.
//          Products from lanes flagged by lane_err are deferred downstream instead of
//          being summed here; an upstream deferred product is absorbed when error_in=1.
// Latency: 2 cycles valid_in -> valid_out (next_activation: 1 cycle); one result per cycle.
// Backpressure: none; the group always accepts valid_in.
// Ports: clk, rst (sync, active-high); bus (slave modport of group_n_mac_ec_if).
module group_n_mac_ec #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int PSW   = 24,
    parameter int EPW   = 2*DW + $clog2(LANES),
    parameter int SAT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    group_n_mac_ec_if.slave bus
);
    localparam int PW = 2*DW;   // per-lane product width
    localparam int SW = PSW+1;  // one carry bit above PSW suffices for legal PSW

    // Stage 1 registers
    logic                  r_s1_vld;
    logic [PW-1:0]         r_s1_prod [LANES];
    logic [LANES-1:0]      r_s1_lane_err;
    logic [PSW-1:0]        r_s1_ps;
    logic [EPW-1:0]        r_s1_ep;
    logic                  r_s1_err_in;
    logic [LANES*DW-1:0]   r_next_act;

    // Stage 2 / output registers
    logic                  r_valid_out;
    logic [PSW-1:0]        r_ps_out;
    logic [EPW-1:0]        r_ep_out;
    logic                  r_error_out;
    logic [15:0]           r_err_count;

    // Stage 2 combinational sums
    logic [SW-1:0]         w_sum;
    logic [EPW-1:0]        w_ep_sum;
    logic [PSW-1:0]        w_ps_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld      <= 1'b0;
            r_s1_lane_err <= '0;
            r_s1_ps       <= '0;
            r_s1_ep       <= '0;
            r_s1_err_in   <= 1'b0;
            r_next_act    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= '0;
            end
        end else begin
            r_s1_vld <= bus.valid_in;
            // Operands and error flags are only captured with valid_in, so stray
            // lane_err/error_in on idle cycles never reach stage 2.
            if (bus.valid_in) begin
                r_next_act    <= bus.activation_in;
                r_s1_lane_err <= bus.lane_err;
                r_s1_ps       <= bus.partial_sum_in;
                r_s1_ep       <= bus.error_product_in;
                r_s1_err_in   <= bus.error_in;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_prod[i] <= PW'(bus.weight_in[i*DW +: DW]) *
                                    PW'(bus.activation_in[i*DW +: DW]);
                end
            end
        end
    end

    // Clean lanes accumulate locally; flagged lanes form the deferred product.
    always_comb begin
        w_sum    = SW'(r_s1_ps);
        w_ep_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_lane_err[i]) begin
                w_ep_sum = w_ep_sum + EPW'(r_s1_prod[i]);
            end else begin
                w_sum = w_sum + SW'(r_s1_prod[i]);
            end
        end
        if (r_s1_err_in) begin
            w_sum = w_sum + SW'(r_s1_ep);
        end
        w_ps_final = w_sum[PSW-1:0];
        if (SAT != 0 && w_sum[PSW]) begin
            w_ps_final = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_ps_out    <= '0;
            r_ep_out    <= '0;
            r_error_out <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_valid_out <= r_s1_vld;
            if (r_s1_vld) begin
                r_ps_out    <= w_ps_final;
                r_ep_out    <= w_ep_sum;
                r_error_out <= |r_s1_lane_err;
                // Counted on the edge that presents the result, so err_count
                // already includes the output currently on the bus.
                if ((|r_s1_lane_err) && (r_err_count != 16'hFFFF)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end else begin
                r_error_out <= 1'b0;
            end
        end
    end

    assign bus.valid_out         = r_valid_out;
    assign bus.next_activation   = r_next_act;
    assign bus.partial_sum_out   = r_ps_out;
    assign bus.error_product_out = r_ep_out;
    assign bus.error_out         = r_error_out;
    assign bus.err_count         = r_err_count;
endmodule

// File: tb/tb_group_n_mac_ec.sv
module tb_group_n_mac_ec;
    typedef struct {
        logic [23:0] ps;
        logic [17:0] ep;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    group_n_mac_ec_if #(.LANES(4), .DW(8), .PSW(24), .EPW(18)) bus0 ();
    group_n_mac_ec_if #(.LANES(4), .DW(8), .PSW(24), .EPW(18)) bus1 ();

    group_n_mac_ec #(.LANES(4), .DW(8), .PSW(24), .EPW(18), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    group_n_mac_ec #(.LANES(4), .DW(8), .PSW(24), .EPW(18), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   e_cnt0 = 0;
    int   e_cnt1 = 0;
    exp_t last0, last1;

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                   input logic [23:0] ps, input logic [17:0] ep,
                                   input logic ei, input logic [3:0] le, input bit sat);
        exp_t   r;
        longint s;
        longint e;
        longint p;
        s = longint'(ps);
        e = 0;
        for (int i = 0; i < 4; i++) begin
            p = longint'(w[i*8 +: 8]) * longint'(a[i*8 +: 8]);
            if (le[i]) e += p;
            else       s += p;
        end
        if (ei) s += longint'(ep);
        if (sat && s > 64'h0000_0000_00FF_FFFF) r.ps = 24'hFFFFFF;
        else                                  r.ps = s[23:0];
        r.ep  = e[17:0];
        r.err = |le;
        return r;
    endfunction

    // Apply one cycle of inputs at the current (falling) edge to both DUTs.
    task automatic drive_now(input logic v, input logic [31:0] w, input logic [31:0] a,
                             input logic [23:0] ps, input logic [17:0] ep,
                             input logic ei, input logic [3:0] le, input logic r);
        rst = r;
        bus0.valid_in = v; bus0.weight_in = w; bus0.activation_in = a;
        bus0.partial_sum_in = ps; bus0.error_product_in = ep;
        bus0.error_in = ei; bus0.lane_err = le;
        bus1.valid_in = v; bus1.weight_in = w; bus1.activation_in = a;
        bus1.partial_sum_in = ps; bus1.error_product_in = ep;
        bus1.error_in = ei; bus1.lane_err = le;
        if (r) begin
            q0.delete(); q1.delete();
            e_cnt0 = 0; e_cnt1 = 0;
        end else if (v) begin
            q0.push_back(model(w, a, ps, ep, ei, le, 1'b0));
            q1.push_back(model(w, a, ps, ep, ei, le, 1'b1));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a,
                         input logic [23:0] ps, input logic [17:0] ep,
                         input logic ei, input logic [3:0] le);
        @(negedge clk);
        drive_now(v, w, a, ps, ep, ei, le, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom, $urandom, 24'($urandom), 18'($urandom),
                  1'b1, 4'hF);
        end
    endtask

    task automatic drain;
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin
            idle(1);
            k++;
        end
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d/%0d required=0/0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
    endtask

    // Scoreboard monitors: sample away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.valid_out === 1'b1) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL wrap_unexpected_valid: valid_out=1 required=0");
            end else begin
                e = q0.pop_front();
                last0 = e;
                if (e.err) e_cnt0++;
                if (bus0.partial_sum_out !== e.ps || bus0.error_product_out !== e.ep ||
                    bus0.error_out !== e.err || bus0.err_count !== 16'(e_cnt0)) begin
                    n_fail++;
                    $display("FAIL wrap_result: ps=%h ep=%h err=%b cnt=%0d required ps=%h ep=%h err=%b cnt=%0d",
                             bus0.partial_sum_out, bus0.error_product_out, bus0.error_out,
                             bus0.err_count, e.ps, e.ep, e.err, e_cnt0);
                end
            end
        end else begin
            n_tests++;
            if (bus0.error_out !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_idle_error_out: error_out=%b required=0", bus0.error_out);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.valid_out === 1'b1) begin
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sat_unexpected_valid: valid_out=1 required=0");
            end else begin
                e = q1.pop_front();
                last1 = e;
                if (e.err) e_cnt1++;
                if (bus1.partial_sum_out !== e.ps || bus1.error_product_out !== e.ep ||
                    bus1.error_out !== e.err || bus1.err_count !== 16'(e_cnt1)) begin
                    n_fail++;
                    $display("FAIL sat_result: ps=%h ep=%h err=%b cnt=%0d required ps=%h ep=%h err=%b cnt=%0d",
                             bus1.partial_sum_out, bus1.error_product_out, bus1.error_out,
                             bus1.err_count, e.ps, e.ep, e.err, e_cnt1);
                end
            end
        end else begin
            n_tests++;
            if (bus1.error_out !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_idle_error_out: error_out=%b required=0", bus1.error_out);
            end
        end
    end

    task automatic test_reset;
        drive_now(1'b0, 32'h0, 32'h0, 24'h0, 18'h0, 1'b0, 4'h0, 1'b1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus0.valid_out !== 1'b0 || bus0.partial_sum_out !== 24'h0 ||
            bus0.error_product_out !== 18'h0 || bus0.error_out !== 1'b0 ||
            bus0.err_count !== 16'h0 || bus0.next_activation !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: vo=%b ps=%h ep=%h eo=%b cnt=%h na=%h required all 0",
                     bus0.valid_out, bus0.partial_sum_out, bus0.error_product_out,
                     bus0.error_out, bus0.err_count, bus0.next_activation);
        end
        drive_now(1'b0, 32'h0, 32'h0, 24'h0, 18'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_basic;
        drive(1'b1, 32'h07050301, 32'h08060402, 24'h008000, 18'h0, 1'b0, 4'h0);
        drive(1'b0, 32'h0, 32'h11223344, 24'h0, 18'h0, 1'b0, 4'h0);
        n_tests++;
        if (bus0.next_activation !== 32'h08060402) begin
            n_fail++;
            $display("FAIL next_activation: got=%h required=%h", bus0.next_activation, 32'h08060402);
        end
        idle(1);
        n_tests++;
        if (bus0.valid_out !== 1'b1 || bus0.partial_sum_out !== 24'h008064) begin
            n_fail++;
            $display("FAIL basic_latency2: vo=%b ps=%h required vo=1 ps=008064",
                     bus0.valid_out, bus0.partial_sum_out);
        end
        n_tests++;
        if (bus0.next_activation !== 32'h08060402) begin
            n_fail++;
            $display("FAIL next_activation_hold: got=%h required=%h", bus0.next_activation, 32'h08060402);
        end
        drain();
    endtask

    task automatic test_lane_err;
        drive(1'b1, 32'h07050301, 32'h08060402, 24'h008000, 18'h0, 1'b0, 4'b1000);
        drain();
        n_tests++;
        if (bus0.partial_sum_out !== 24'h00802C || bus0.error_product_out !== 18'h038 ||
            bus0.err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL lane_err: ps=%h ep=%h cnt=%0d required ps=00802c ep=038 cnt=1",
                     bus0.partial_sum_out, bus0.error_product_out, bus0.err_count);
        end
    endtask

    task automatic test_error_in;
        drive(1'b1, 32'h02040608, 32'h01030507, 24'h001000, 18'h012, 1'b1, 4'h0);
        drain();
        n_tests++;
        if (bus0.partial_sum_out !== 24'h001076) begin
            n_fail++;
            $display("FAIL error_in_comp: ps=%h required=001076", bus0.partial_sum_out);
        end
    endtask

    task automatic test_saturation;
        drive(1'b1, 32'h07050301, 32'h08060402, 24'hFFFFF0, 18'h0, 1'b0, 4'h0);
        drain();
        n_tests++;
        if (bus0.partial_sum_out !== 24'h000054 || bus1.partial_sum_out !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL saturation: wrap=%h sat=%h required wrap=000054 sat=ffffff",
                     bus0.partial_sum_out, bus1.partial_sum_out);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, $urandom, $urandom, 24'($urandom), 18'($urandom),
                  1'($urandom), 4'($urandom));
            if (i >= 2) begin
                n_tests++;
                if (bus0.valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back_rate: vo=%b required=1 at beat %0d", bus0.valid_out, i);
                end
            end
        end
        drain();
    endtask

    task automatic test_valid_gating;
        logic [31:0] na;
        na = bus0.next_activation;
        idle(5);
        n_tests++;
        if (bus0.valid_out !== 1'b0 || bus0.partial_sum_out !== last0.ps ||
            bus0.error_product_out !== last0.ep || bus1.partial_sum_out !== last1.ps ||
            bus0.next_activation !== na) begin
            n_fail++;
            $display("FAIL idle_hold: vo=%b ps=%h ep=%h sps=%h na=%h required vo=0 ps=%h ep=%h sps=%h na=%h",
                     bus0.valid_out, bus0.partial_sum_out, bus0.error_product_out,
                     bus1.partial_sum_out, bus0.next_activation,
                     last0.ps, last0.ep, last1.ps, na);
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 32'h01010101, 32'h01010101, 24'h000100, 18'h0, 1'b0, 4'b0001);
        @(negedge clk);
        drive_now(1'b1, 32'h02020202, 32'h02020202, 24'h000200, 18'h0, 1'b0, 4'b0010, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus0.valid_out !== 1'b0 || bus0.partial_sum_out !== 24'h0 ||
            bus0.error_product_out !== 18'h0 || bus0.error_out !== 1'b0 ||
            bus0.err_count !== 16'h0 || bus0.next_activation !== 32'h0) begin
            n_fail++;
            $display("FAIL midstream_reset_clear: vo=%b ps=%h ep=%h eo=%b cnt=%h na=%h required all 0",
                     bus0.valid_out, bus0.partial_sum_out, bus0.error_product_out,
                     bus0.error_out, bus0.err_count, bus0.next_activation);
        end
        drive_now(1'b1, 32'h03030303, 32'h03030303, 24'h000300, 18'h0, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 32'h04040404, 32'h04040404, 24'h000400, 18'h0, 1'b0, 4'b0100);
        idle(1);
        n_tests++;
        if (bus0.valid_out !== 1'b1 || bus0.partial_sum_out !== 24'h000324) begin
            n_fail++;
            $display("FAIL post_reset_first: vo=%b ps=%h required vo=1 ps=000324",
                     bus0.valid_out, bus0.partial_sum_out);
        end
        drain();
    endtask

    initial begin
        drive_now(1'b0, 32'h0, 32'h0, 24'h0, 18'h0, 1'b0, 4'h0, 1'b1);
        test_reset();
        test_basic();
        test_lane_err();
        test_error_in();
        test_saturation();
        test_back_to_back();
        test_valid_gating();
        test_reset_midstream();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
